// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch and the data stage.
// One transaction in flight at a time; data wins ties, but IF gets a forced turn after a DM streak.
module mem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int XLEN          = 32,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_kill,
    output logic                if_ack,
    output logic [XLEN-1:0]     if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [XLEN/8-1:0]   dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [XLEN-1:0]     dm_wdata,
    output logic                dm_ack,
    output logic [XLEN-1:0]     dm_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [XLEN/8-1:0]   mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic                stall_fetch,
    output logic                stall_mem
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);

    state_t     state_reg;
    owner_t     owner_reg;
    logic       kill_pend_reg;
    logic [3:0] dm_streak_reg;

    logic if_live;
    logic grant_dm;
    logic grant_if;
    logic resp_done;

    // A killed fetch no longer competes for the port.
    assign if_live   = if_req && !if_kill;
    assign grant_dm  = dm_req && !(if_live && (dm_streak_reg == STREAK_MAX));
    assign grant_if  = !grant_dm && if_live;
    assign resp_done = (state_reg == RESP) && mem_rvalid;

    assign dm_ack   = resp_done && (owner_reg == OWN_DM);
    assign if_ack   = resp_done && (owner_reg == OWN_IF) && !kill_pend_reg;
    assign dm_rdata = mem_rdata;
    assign if_rdata = mem_rdata;

    assign stall_mem   = dm_req && !dm_ack;
    assign stall_fetch = (if_req && !if_ack && !if_kill) || stall_mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            owner_reg     <= OWN_NONE;
            kill_pend_reg <= 1'b0;
            dm_streak_reg <= 4'd0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_be        <= '0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    kill_pend_reg <= 1'b0;
                    if (grant_dm) begin
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_be    <= dm_be;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        owner_reg <= OWN_DM;
                        state_reg <= REQ;
                        // Streak only counts DM grants that actually made IF wait.
                        if (!if_req) begin
                            dm_streak_reg <= 4'd0;
                        end else if (dm_streak_reg != STREAK_MAX) begin
                            dm_streak_reg <= dm_streak_reg + 4'd1;
                        end
                    end else if (grant_if) begin
                        mem_req       <= 1'b1;
                        mem_we        <= 1'b0;
                        mem_be        <= '1;
                        mem_addr      <= if_addr;
                        mem_wdata     <= '0;
                        owner_reg     <= OWN_IF;
                        state_reg     <= REQ;
                        dm_streak_reg <= 4'd0;
                    end
                end
                REQ: begin
                    if (if_kill && (owner_reg == OWN_IF)) begin
                        kill_pend_reg <= 1'b1;
                    end
                    if (mem_gnt) begin
                        mem_req   <= 1'b0;
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    if (mem_rvalid) begin
                        state_reg     <= IDLE;
                        owner_reg     <= OWN_NONE;
                        kill_pend_reg <= 1'b0;
                    end else if (if_kill && (owner_reg == OWN_IF)) begin
                        kill_pend_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    owner_reg <= OWN_NONE;
                end
            endcase
        end
    end

endmodule
